// File: rtl/axis_data_width_downsizer.sv
// AXI4-Stream width downsizer: each wide input word is emitted as N narrow slices,
// LSB slice first, with tlast marking the final slice of every word.
`timescale 1ns/1ps

module axis_data_width_downsizer #(
    parameter int AXIS_TDATA_WIDTH_IN  = 32,
    parameter int AXIS_TDATA_WIDTH_OUT = 16
) (
    input  logic                            aclk,
    input  logic                            aresetn,
    input  logic                            S_AXIS_tvalid,
    input  logic [AXIS_TDATA_WIDTH_IN-1:0]  S_AXIS_tdata,
    output logic                            S_AXIS_tready,
    input  logic                            M_AXIS_tready,
    output logic                            M_AXIS_tvalid,
    output logic [AXIS_TDATA_WIDTH_OUT-1:0] M_AXIS_tdata,
    output logic                            M_AXIS_tlast
);

    // Input width must be an integer multiple (>= 2) of the output width.
    localparam int N     = AXIS_TDATA_WIDTH_IN / AXIS_TDATA_WIDTH_OUT;
    localparam int CNT_W = $clog2(N);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        BUSY  = 1'b1
    } state_t;

    state_t                                   state, next_state;
    logic [CNT_W-1:0]                         cnt, next_cnt;
    logic [N-1:0][AXIS_TDATA_WIDTH_OUT-1:0]   data_reg, next_data;

    logic full;
    logic last_slice;
    logic in_hs;
    logic out_hs;

    assign full       = (state == BUSY);
    assign last_slice = (cnt == LAST_CNT);
    assign in_hs      = S_AXIS_tvalid & S_AXIS_tready;
    assign out_hs     = full & M_AXIS_tready;

    // NOTE: state is updated with non-blocking assignments and the data register
    // is cleared on reset too, so tdata reads zero while the block is held in reset.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state    <= EMPTY;
            cnt      <= '0;
            data_reg <= '0;
        end else begin
            state    <= next_state;
            cnt      <= next_cnt;
            data_reg <= next_data;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        next_data  = data_reg;
        case (state)
            EMPTY: begin
                if (in_hs) begin
                    next_state = BUSY;
                    next_cnt   = '0;
                    next_data  = S_AXIS_tdata;
                end
            end
            BUSY: begin
                if (out_hs) begin
                    if (!last_slice) begin
                        next_cnt = cnt + 1'b1;
                    end else if (in_hs) begin
                        // Refill on the last slice so back-to-back words have no bubble.
                        next_cnt  = '0;
                        next_data = S_AXIS_tdata;
                    end else begin
                        next_state = EMPTY;
                        next_cnt   = '0;
                    end
                end
            end
        endcase
    end

    always_comb begin
        S_AXIS_tready = !full | (M_AXIS_tready & last_slice);
        M_AXIS_tvalid = full;
        M_AXIS_tdata  = data_reg[cnt];
        M_AXIS_tlast  = full & last_slice;
    end

endmodule

// File: tb/tb_axis_data_width_downsizer.sv
// Self-checking bench for axis_data_width_downsizer: directed cases for ratios 2 and 4
// plus a randomized run checked against a slice-queue reference model.
`timescale 1ns/1ps

module tb_axis_data_width_downsizer;

    localparam int NUM_WORDS  = 10000;
    localparam int MAX_CYCLES = 60000;

    logic        aclk;
    logic        aresetn;

    logic        s_tvalid;
    logic [31:0] s_tdata;
    logic        s_tready;
    logic        m_tready;
    logic        m_tvalid;
    logic [15:0] m_tdata;
    logic        m_tlast;

    logic        s4_tvalid;
    logic [31:0] s4_tdata;
    logic        s4_tready;
    logic        m4_tready;
    logic        m4_tvalid;
    logic [7:0]  m4_tdata;
    logic        m4_tlast;

    int checks = 0;
    int errors = 0;

    axis_data_width_downsizer #(
        .AXIS_TDATA_WIDTH_IN (32),
        .AXIS_TDATA_WIDTH_OUT(16)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .S_AXIS_tvalid(s_tvalid),
        .S_AXIS_tdata (s_tdata),
        .S_AXIS_tready(s_tready),
        .M_AXIS_tready(m_tready),
        .M_AXIS_tvalid(m_tvalid),
        .M_AXIS_tdata (m_tdata),
        .M_AXIS_tlast (m_tlast)
    );

    axis_data_width_downsizer #(
        .AXIS_TDATA_WIDTH_IN (32),
        .AXIS_TDATA_WIDTH_OUT(8)
    ) dut4 (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .S_AXIS_tvalid(s4_tvalid),
        .S_AXIS_tdata (s4_tdata),
        .S_AXIS_tready(s4_tready),
        .M_AXIS_tready(m4_tready),
        .M_AXIS_tvalid(m4_tvalid),
        .M_AXIS_tdata (m4_tdata),
        .M_AXIS_tlast (m4_tlast)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns later, well before the rising edge.
    task automatic drive(input logic v, input logic [31:0] d, input logic r);
        @(negedge aclk);
        s_tvalid = v;
        s_tdata  = d;
        m_tready = r;
        #1;
    endtask

    task automatic expect_slice(input string tag, input logic [15:0] data, input logic last);
        check({tag, "_tvalid"}, 32'(m_tvalid), 32'd1);
        check({tag, "_tdata"},  32'(m_tdata),  32'(data));
        check({tag, "_tlast"},  32'(m_tlast),  32'(last));
    endtask

    task automatic expect_reset_outputs(input string tag);
        check({tag, "_tvalid"}, 32'(m_tvalid), 32'd0);
        check({tag, "_tlast"},  32'(m_tlast),  32'd0);
        check({tag, "_tdata"},  32'(m_tdata),  32'd0);
        check({tag, "_tready"}, 32'(s_tready), 32'd1);
    endtask

    initial begin
        logic [15:0] exp_q[$];
        logic [31:0] word4;
        int          words_sent;
        int          slices_out;
        int          cycles;

        aresetn   = 1'b0;
        s_tvalid  = 1'b1;
        s_tdata   = 32'hFFFF_FFFF;
        m_tready  = 1'b1;
        s4_tvalid = 1'b1;
        s4_tdata  = 32'hFFFF_FFFF;
        m4_tready = 1'b1;

        // Reset with input offered: nothing may be captured.
        repeat (3) @(posedge aclk);
        #1;
        expect_reset_outputs("rst");
        check("rst4_tvalid", 32'(m4_tvalid), 32'd0);
        @(negedge aclk);
        s_tvalid  = 1'b0;
        s4_tvalid = 1'b0;
        aresetn   = 1'b1;
        #1;
        check("post_rst_tvalid", 32'(m_tvalid), 32'd0);
        check("post_rst4_tready", 32'(s4_tready), 32'd1);

        // Single word.
        drive(1'b1, 32'hAABB_1122, 1'b1);
        check("single_accept_tready", 32'(s_tready), 32'd1);
        drive(1'b0, 32'h0, 1'b1);
        expect_slice("single_s0", 16'h1122, 1'b0);
        drive(1'b0, 32'h0, 1'b1);
        expect_slice("single_s1", 16'hAABB, 1'b1);
        drive(1'b0, 32'h0, 1'b1);
        check("single_idle_tvalid", 32'(m_tvalid), 32'd0);

        // Back-to-back words with no bubble.
        drive(1'b1, 32'h0001_0002, 1'b1);
        drive(1'b1, 32'h0003_0004, 1'b1);
        expect_slice("b2b_s0", 16'h0002, 1'b0);
        check("b2b_s0_tready", 32'(s_tready), 32'd0);
        drive(1'b1, 32'h0003_0004, 1'b1);
        expect_slice("b2b_s1", 16'h0001, 1'b1);
        check("b2b_s1_tready", 32'(s_tready), 32'd1);
        drive(1'b0, 32'h0, 1'b1);
        expect_slice("b2b_s2", 16'h0004, 1'b0);
        check("b2b_s2_tready", 32'(s_tready), 32'd0);
        drive(1'b0, 32'h0, 1'b1);
        expect_slice("b2b_s3", 16'h0003, 1'b1);
        check("b2b_s3_tready", 32'(s_tready), 32'd1);
        drive(1'b0, 32'h0, 1'b1);
        check("b2b_idle_tvalid", 32'(m_tvalid), 32'd0);

        // Backpressure holds slice 0 stable.
        drive(1'b1, 32'hDEAD_BEEF, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h5555_5555, 1'b0);
            expect_slice("bp_hold", 16'hBEEF, 1'b0);
            check("bp_hold_tready", 32'(s_tready), 32'd0);
        end
        drive(1'b0, 32'h0, 1'b1);
        expect_slice("bp_rel_s0", 16'hBEEF, 1'b0);
        drive(1'b0, 32'h0, 1'b1);
        expect_slice("bp_rel_s1", 16'hDEAD, 1'b1);
        drive(1'b0, 32'h0, 1'b1);
        check("bp_idle_tvalid", 32'(m_tvalid), 32'd0);

        // Ratio 4 instance.
        word4 = 32'h4433_2211;
        @(negedge aclk);
        s4_tvalid = 1'b1;
        s4_tdata  = word4;
        m4_tready = 1'b1;
        #1;
        check("r4_accept_tready", 32'(s4_tready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            s4_tvalid = 1'b0;
            #1;
            check("r4_tvalid", 32'(m4_tvalid), 32'd1);
            check("r4_tdata",  32'(m4_tdata),  (word4 >> (8 * i)) & 32'hFF);
            check("r4_tlast",  32'(m4_tlast),  32'(i == 3));
        end
        @(negedge aclk);
        #1;
        check("r4_idle_tvalid", 32'(m4_tvalid), 32'd0);

        // Reset mid-word discards the pending slice.
        drive(1'b1, 32'h1234_5678, 1'b1);
        drive(1'b0, 32'h0, 1'b1);
        expect_slice("mid_s0", 16'h5678, 1'b0);
        drive(1'b0, 32'h0, 1'b0);
        expect_slice("mid_s1_pending", 16'h1234, 1'b1);
        #2;
        aresetn  = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = 32'hFFFF_FFFF;
        #1;
        expect_reset_outputs("mid_async");
        repeat (2) @(posedge aclk);
        #1;
        expect_reset_outputs("mid_hold");
        @(negedge aclk);
        s_tvalid = 1'b0;
        aresetn  = 1'b1;
        #1;
        check("mid_release_tvalid", 32'(m_tvalid), 32'd0);
        drive(1'b1, 32'h0000_ABCD, 1'b1);
        drive(1'b0, 32'h0, 1'b1);
        expect_slice("mid_new_s0", 16'hABCD, 1'b0);
        drive(1'b0, 32'h0, 1'b1);
        expect_slice("mid_new_s1", 16'h0000, 1'b1);
        drive(1'b0, 32'h0, 1'b1);
        check("mid_new_idle_tvalid", 32'(m_tvalid), 32'd0);

        // Random traffic against a queue of expected slices still owed to the master.
        words_sent = 0;
        slices_out = 0;
        cycles     = 0;
        while ((words_sent < NUM_WORDS || exp_q.size() != 0) && cycles < MAX_CYCLES) begin
            logic        v;
            logic        r;
            logic        exp_rdy;
            logic [31:0] d;
            v = (words_sent < NUM_WORDS) && ($urandom_range(3) != 0);
            r = ($urandom_range(3) != 0);
            d = $urandom;
            drive(v, d, r);
            exp_rdy = (exp_q.size() == 0) || (exp_q.size() == 1 && r);
            check("rnd_s_tready", 32'(s_tready), 32'(exp_rdy));
            check("rnd_m_tvalid", 32'(m_tvalid), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                check("rnd_m_tdata", 32'(m_tdata), 32'(exp_q[0]));
                check("rnd_m_tlast", 32'(m_tlast), 32'(exp_q.size() == 1));
            end
            if (r && exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                slices_out++;
            end
            if (v && exp_rdy) begin
                exp_q.push_back(d[15:0]);
                exp_q.push_back(d[31:16]);
                words_sent++;
            end
            cycles++;
        end
        check("rnd_words_sent", 32'(words_sent), 32'(NUM_WORDS));
        check("rnd_slices_out", 32'(slices_out), 32'(2 * NUM_WORDS));
        check("rnd_leftover", 32'(exp_q.size()), 32'd0);
        drive(1'b0, 32'h0, 1'b1);
        check("rnd_idle_tvalid", 32'(m_tvalid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_data_width_downsizer.md
AXIS_DATA_WIDTH_DOWNSIZER -- requirements
Module: axis_data_width_downsizer

Interface
REQ-001 SHALL have parameter AXIS_TDATA_WIDTH_IN, default 32, input tdata width.
REQ-002 SHALL have parameter AXIS_TDATA_WIDTH_OUT, default 16, output tdata width.
REQ-003 SHALL require AXIS_TDATA_WIDTH_IN = N x AXIS_TDATA_WIDTH_OUT, integer N >= 2; other values unsupported.
REQ-004 SHALL have port aclk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port aresetn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port S_AXIS_tvalid  input  1  slave word valid.
REQ-007 SHALL have port S_AXIS_tdata  input  AXIS_TDATA_WIDTH_IN  slave wide word.
REQ-008 SHALL have port S_AXIS_tready  output  1  slave ready.
REQ-009 SHALL have port M_AXIS_tready  input  1  master ready.
REQ-010 SHALL have port M_AXIS_tvalid  output  1  master slice valid.
REQ-011 SHALL have port M_AXIS_tdata  output  AXIS_TDATA_WIDTH_OUT  master narrow slice.
REQ-012 SHALL have port M_AXIS_tlast  output  1  high on final slice of each wide word.

Function
REQ-013 SHALL hold one wide word in register data_reg plus slice index cnt (0..N-1) and flag full.
REQ-014 SHALL use two states: EMPTY (full=0) and BUSY (full=1).
REQ-015 SHALL accept input when S_AXIS_tvalid & S_AXIS_tready on a rising edge.
REQ-016 SHALL drive S_AXIS_tready = !full | (M_AXIS_tready & cnt==N-1), combinationally.
REQ-017 SHALL drive M_AXIS_tvalid = full; no combinational path from S_AXIS_tvalid to M_AXIS_tvalid.
REQ-018 SHALL drive M_AXIS_tdata = data_reg[cnt*OUT +: OUT]; slice 0 (LSBs) first, MSBs last.
REQ-019 SHALL drive M_AXIS_tlast = full & cnt==N-1.
REQ-020 EMPTY + accept: load data_reg, cnt<=0, go BUSY; first slice valid 1 cycle after accept.
REQ-021 BUSY + output handshake with cnt<N-1: cnt<=cnt+1, data_reg unchanged.
REQ-022 BUSY + output handshake with cnt==N-1 and no accept: cnt<=0, go EMPTY.
REQ-023 BUSY + output handshake with cnt==N-1 and simultaneous accept: load new word, cnt<=0, stay BUSY (no bubble).
REQ-024 BUSY without output handshake: hold data_reg, cnt, M_AXIS_tdata, M_AXIS_tlast stable (AXIS stability).
REQ-025 Sustained throughput SHALL be one output slice per cycle with M_AXIS_tready high; one input word per N cycles.
REQ-026 No data loss or duplication under arbitrary tvalid/tready patterns; no data reordering.

Reset
REQ-027 aresetn low SHALL immediately force full=0, cnt=0, data_reg=0, regardless of clock.
REQ-028 During reset SHALL output M_AXIS_tvalid=0, M_AXIS_tlast=0, M_AXIS_tdata=0, S_AXIS_tready=1 once full=0.
REQ-029 Reset mid-word SHALL discard remaining slices; first edge after release behaves as EMPTY.
REQ-030 Input presented during reset SHALL NOT be captured.

Verification
REQ-031 Single word: IN=32,OUT=16, send 0xAABB1122, M ready=1 -> outputs 0x1122 (tlast=0) then 0xAABB (tlast=1), then tvalid=0.
REQ-032 Back-to-back: words 0x00010002, 0x00030004 with S valid held, M ready=1 -> slices 0x0002,0x0001,0x0004,0x0003 on 4 consecutive cycles; S_AXIS_tready high only on 2nd-slice cycles.
REQ-033 Backpressure: M ready low 3 cycles during slice 0 of 0xDEADBEEF -> M_AXIS_tdata stays 0xBEEF, S_AXIS_tready=0; release -> 0xBEEF, 0xDEAD.
REQ-034 Ratio 4: IN=32,OUT=8, word 0x44332211 -> 0x11,0x22,0x33,0x44, tlast only on 0x44.
REQ-035 Reset mid-word: assert aresetn=0 after slice 0 of 0x12345678 -> M_AXIS_tvalid=0 asynchronously; after release, new word 0x0000ABCD yields 0xABCD,0x0000 only.
REQ-036 Random: random S valid / M ready for 10k words -> scoreboard matches all slices in order, zero loss.
